// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register indices, exception codes and the SR/Cause field positions.
package cp0_defs;

  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  typedef enum logic [4:0] {
    EXC_INT = 5'd0,
    EXC_RI  = 5'd10,
    EXC_OV  = 5'd12
  } exc_code_e;

  localparam int unsigned SR_IM_HI     = 15;
  localparam int unsigned SR_IM_LO     = 10;
  localparam int unsigned SR_EXL       = 1;
  localparam int unsigned SR_IE        = 0;

  localparam int unsigned CAUSE_BD     = 31;
  localparam int unsigned CAUSE_IP_HI  = 15;
  localparam int unsigned CAUSE_IP_LO  = 10;
  localparam int unsigned CAUSE_EXC_HI = 6;
  localparam int unsigned CAUSE_EXC_LO = 2;

endpackage

// File: rtl/cp0_exc_arbiter.sv
// Combinational interrupt/exception arbitration; interrupts win over RI, RI over Ov.
module cp0_exc_arbiter
  import cp0_defs::*;
(
  input  logic [5:0] hwint,
  input  logic [5:0] im,
  input  logic       ie,
  input  logic       exl,
  input  logic       exc_ri,
  input  logic       exc_ov,
  output logic       exc_req,
  output exc_code_e  excode
);

  logic int_pend;
  logic exc_pend;

  // Uses live hwint rather than the registered IP so the interrupt is taken without a cycle of lag.
  assign int_pend = (|(hwint & im)) & ie & ~exl;
  assign exc_pend = (exc_ov | exc_ri) & ~exl;
  assign exc_req  = int_pend | exc_pend;

  always_comb begin
    excode = EXC_OV;
    if (int_pend) begin
      excode = EXC_INT;
    end else if (exc_ri) begin
      excode = EXC_RI;
    end
  end

endmodule

// File: rtl/cp0_unit.sv
// Coprocessor 0: SR, Cause, EPC and PRId registers plus exception entry and ERET return.
module cp0_unit
  import cp0_defs::*;
#(
  parameter logic [31:0] PRID         = 32'h4D49_5053,
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        is_bd,
  input  logic [4:0]  sel,
  input  logic [31:0] din,
  input  logic        cp0_we,
  input  logic        eret,
  input  logic        exc_ov,
  input  logic        exc_ri,
  input  logic [5:0]  hwint,
  output logic [31:0] dout,
  output logic [31:0] epc_out,
  output logic        exc_req,
  output logic [31:0] exc_target
);

  logic [5:0]  im_q, im_d;
  logic        exl_q, exl_d;
  logic        ie_q, ie_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;
  exc_code_e   exc_code_q, exc_code_d;
  logic [29:0] epc_q, epc_d;

  exc_code_e   excode;
  logic [31:0] epc_next;
  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] epc_val;
  logic        unused_epc_lsb;

  cp0_exc_arbiter u_arb (
    .hwint   (hwint),
    .im      (im_q),
    .ie      (ie_q),
    .exl     (exl_q),
    .exc_ri  (exc_ri),
    .exc_ov  (exc_ov),
    .exc_req (exc_req),
    .excode  (excode)
  );

  assign epc_next       = is_bd ? (pc - 32'd4) : pc;
  assign unused_epc_lsb = ^epc_next[1:0];

  always_comb begin
    im_d       = im_q;
    exl_d      = exl_q;
    ie_d       = ie_q;
    bd_d       = bd_q;
    ip_d       = hwint;
    exc_code_d = exc_code_q;
    epc_d      = epc_q;
    // Exception entry outranks ERET, which outranks mtc0; only one of them acts per edge.
    if (exc_req) begin
      exl_d      = 1'b1;
      exc_code_d = excode;
      bd_d       = is_bd;
      epc_d      = epc_next[31:2];
    end else if (eret) begin
      exl_d = 1'b0;
    end else if (cp0_we) begin
      case (sel)
        REG_SR: begin
          im_d  = din[SR_IM_HI:SR_IM_LO];
          exl_d = din[SR_EXL];
          ie_d  = din[SR_IE];
        end
        REG_EPC: epc_d = din[31:2];
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      bd_q       <= 1'b0;
      ip_q       <= '0;
      exc_code_q <= EXC_INT;
      epc_q      <= '0;
    end else begin
      im_q       <= im_d;
      exl_q      <= exl_d;
      ie_q       <= ie_d;
      bd_q       <= bd_d;
      ip_q       <= ip_d;
      exc_code_q <= exc_code_d;
      epc_q      <= epc_d;
    end
  end

  always_comb begin
    sr_val                            = '0;
    sr_val[SR_IM_HI:SR_IM_LO]         = im_q;
    sr_val[SR_EXL]                    = exl_q;
    sr_val[SR_IE]                     = ie_q;
    cause_val                         = '0;
    cause_val[CAUSE_BD]               = bd_q;
    cause_val[CAUSE_IP_HI:CAUSE_IP_LO] = ip_q;
    cause_val[CAUSE_EXC_HI:CAUSE_EXC_LO] = exc_code_q;
    epc_val                           = {epc_q, 2'b00};
  end

  always_comb begin
    dout = '0;
    case (sel)
      REG_SR:    dout = sr_val;
      REG_CAUSE: dout = cause_val;
      REG_EPC:   dout = epc_val;
      REG_PRID:  dout = PRID;
      default:   dout = '0;
    endcase
  end

  assign epc_out    = epc_val;
  assign exc_target = HANDLER_ADDR;

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit with a queue of expected values popped at each observation.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        is_bd;
  logic [4:0]  sel;
  logic [31:0] din;
  logic        cp0_we;
  logic        eret;
  logic        exc_ov;
  logic        exc_ri;
  logic [5:0]  hwint;
  logic [31:0] dout;
  logic [31:0] epc_out;
  logic        exc_req;
  logic [31:0] exc_target;

  localparam logic [31:0] PRID_V = 32'h4D49_5053;
  localparam logic [31:0] HND_V  = 32'h0000_4180;

  cp0_unit #(.PRID(PRID_V), .HANDLER_ADDR(HND_V)) dut (
    .clk        (clk),
    .reset      (reset),
    .pc         (pc),
    .is_bd      (is_bd),
    .sel        (sel),
    .din        (din),
    .cp0_we     (cp0_we),
    .eret       (eret),
    .exc_ov     (exc_ov),
    .exc_ri     (exc_ri),
    .hwint      (hwint),
    .dout       (dout),
    .epc_out    (epc_out),
    .exc_req    (exc_req),
    .exc_target (exc_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic push_exp(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic rd(input string tag, input logic [4:0] s, input logic [31:0] v);
    sel = s;
    push_exp(tag, v);
    #1;
    chk(dout);
  endtask

  task automatic req(input string tag, input logic v);
    push_exp(tag, {31'b0, v});
    #1;
    chk({31'b0, exc_req});
  endtask

  task automatic epc_chk(input string tag, input logic [31:0] v);
    push_exp(tag, v);
    #1;
    chk(epc_out);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cp0_we = 1'b0;
    eret   = 1'b0;
    exc_ov = 1'b0;
    exc_ri = 1'b0;
    is_bd  = 1'b0;
  endtask

  task automatic mtc0(input logic [4:0] s, input logic [31:0] d);
    sel    = s;
    din    = d;
    cp0_we = 1'b1;
    tick();
  endtask

  initial begin
    reset = 1'b1; pc = 32'h0000_3000; is_bd = 1'b0; sel = 5'd0; din = '0;
    cp0_we = 1'b0; eret = 1'b0; exc_ov = 1'b0; exc_ri = 1'b0; hwint = '0;
    #2;
    rd("rst_sr", 5'd12, 32'h0);
    rd("rst_cause", 5'd13, 32'h0);
    rd("rst_prid", 5'd15, PRID_V);
    rd("unmapped_sel", 5'd3, 32'h0);
    epc_chk("rst_epc_out", 32'h0);
    req("rst_exc_req", 1'b0);
    push_exp("exc_target", HND_V); chk(exc_target);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // mtc0 SR: read before the edge shows old value, after shows new
    sel = 5'd12; din = 32'h0000_FC01; cp0_we = 1'b1;
    push_exp("sr_no_bypass", 32'h0); #1; chk(dout);
    tick();
    rd("sr_written", 5'd12, 32'h0000_FC01);
    hwint = 6'b000100;
    req("int_req_same_cycle", 1'b1);
    tick();
    rd("int_cause", 5'd13, 32'h0000_1000);
    rd("int_sr_exl", 5'd12, 32'h0000_FC03);
    req("int_req_masked_by_exl", 1'b0);
    epc_chk("int_epc", 32'h0000_3000);

    // overflow with SR cleared
    hwint = '0;
    mtc0(5'd12, 32'h0);
    pc = 32'h0000_3010; exc_ov = 1'b1;
    req("ov_req", 1'b1);
    tick();
    epc_chk("ov_epc", 32'h0000_3010);
    rd("ov_cause", 5'd13, 32'h0000_0030);
    rd("ov_sr", 5'd12, 32'h0000_0002);

    // RI beats Ov, branch delay slot
    mtc0(5'd12, 32'h0);
    pc = 32'h0000_3020; is_bd = 1'b1; exc_ri = 1'b1; exc_ov = 1'b1;
    tick();
    rd("ri_cause", 5'd13, 32'h8000_0028);
    epc_chk("ri_epc_bd", 32'h0000_301C);

    // EXL blocks new requests; eret re-enables
    mtc0(5'd12, 32'h0000_FC03);
    hwint = 6'b000001; pc = 32'h0000_5000; exc_ov = 1'b1;
    req("exl_blocks", 1'b0);
    tick();
    epc_chk("exl_epc_kept", 32'h0000_301C);
    rd("exl_cause_kept", 5'd13, 32'h8000_0428);
    eret = 1'b1;
    req("eret_cycle_req", 1'b0);
    tick();
    rd("eret_sr", 5'd12, 32'h0000_FC01);
    req("int_after_eret", 1'b1);
    hwint = '0;
    req("int_deasserted", 1'b0);

    // exception wins over same-cycle mtc0 EPC
    pc = 32'h0000_6000; sel = 5'd14; din = 32'h0000_3047; cp0_we = 1'b1; exc_ri = 1'b1;
    tick();
    epc_chk("exc_beats_mtc0", 32'h0000_6000);
    rd("exc_beats_mtc0_cause", 5'd13, 32'h0000_0028);
    mtc0(5'd14, 32'h0000_3047);
    epc_chk("mtc0_epc_aligned", 32'h0000_3044);
    rd("mtc0_epc_dout", 5'd14, 32'h0000_3044);
    mtc0(5'd13, 32'hFFFF_FFFF);
    rd("cause_read_only", 5'd13, 32'h0000_0028);
    mtc0(5'd15, 32'h0);
    rd("prid_read_only", 5'd15, PRID_V);

    // pc-4 wraps modulo 2^32
    mtc0(5'd12, 32'h0);
    pc = 32'h0; is_bd = 1'b1; exc_ov = 1'b1;
    tick();
    epc_chk("epc_wrap", 32'hFFFF_FFFC);
    rd("wrap_cause", 5'd13, 32'h8000_0030);
    rd("wrap_sr_exl", 5'd12, 32'h0000_0002);

    // asynchronous reset mid-cycle
    hwint = 6'b111111;
    #2;
    reset = 1'b1;
    rd("arst_sr", 5'd12, 32'h0);
    rd("arst_cause", 5'd13, 32'h0);
    rd("arst_epc", 5'd14, 32'h0);
    rd("arst_prid", 5'd15, PRID_V);
    epc_chk("arst_epc_out", 32'h0);
    req("arst_exc_req", 1'b0);
    @(negedge clk);
    reset = 1'b0;
    hwint = '0;
    tick();

    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
